// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush/bubble handling and multi-cycle MAC scratch return.
// Optional load/store payload (aluop, memory address, store data) enabled by `define EX_MEM_LS_EN.
module ex_mem_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned CNT_W  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5:0]          stall,
   input  logic                flush,
   input  logic [ADDR_W-1:0]   ex_wd,
   input  logic                ex_wreg,
   input  logic [DATA_W-1:0]   ex_wdata,
   input  logic                ex_whilo,
   input  logic [DATA_W-1:0]   ex_hi,
   input  logic [DATA_W-1:0]   ex_lo,
   input  logic [2*DATA_W-1:0] hilo_i,
   input  logic [CNT_W-1:0]    cnt_i,
   output logic [ADDR_W-1:0]   mem_wd,
   output logic                mem_wreg,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic                mem_whilo,
   output logic [DATA_W-1:0]   mem_hi,
   output logic [DATA_W-1:0]   mem_lo,
   output logic [2*DATA_W-1:0] hilo_o,
   output logic [CNT_W-1:0]    cnt_o
`ifdef EX_MEM_LS_EN
   ,
   input  logic [7:0]          ex_aluop,
   input  logic [DATA_W-1:0]   ex_mem_addr,
   input  logic [DATA_W-1:0]   ex_reg2,
   output logic [7:0]          mem_aluop,
   output logic [DATA_W-1:0]   mem_mem_addr,
   output logic [DATA_W-1:0]   mem_reg2
`endif
);

   localparam int unsigned ExStall  = 3;
   localparam int unsigned MemStall = 4;

   typedef enum logic [1:0] {
      ActClear,
      ActAdvance,
      ActBubble,
      ActHold
   } act_e;

   act_e act;

   logic [ADDR_W-1:0]   mem_wd_d;
   logic                mem_wreg_d;
   logic [DATA_W-1:0]   mem_wdata_d;
   logic                mem_whilo_d;
   logic [DATA_W-1:0]   mem_hi_d;
   logic [DATA_W-1:0]   mem_lo_d;
   logic [2*DATA_W-1:0] hilo_d;
   logic [CNT_W-1:0]    cnt_d;
`ifdef EX_MEM_LS_EN
   logic [7:0]          mem_aluop_d;
   logic [DATA_W-1:0]   mem_mem_addr_d;
   logic [DATA_W-1:0]   mem_reg2_d;
`endif

   // Only the EX and MEM stall bits matter at this boundary.
   logic unused_stall;
   assign unused_stall = ^{stall[5], stall[2:0]};

   // Flush beats stall; EX running with MEM stalled cannot occur and is treated as advance.
   always_comb begin
      act = ActHold;
      if (rst || flush) begin
         act = ActClear;
      end else if (!stall[ExStall]) begin
         act = ActAdvance;
      end else if (!stall[MemStall]) begin
         act = ActBubble;
      end
   end

   always_comb begin
      mem_wd_d    = mem_wd;
      mem_wreg_d  = mem_wreg;
      mem_wdata_d = mem_wdata;
      mem_whilo_d = mem_whilo;
      mem_hi_d    = mem_hi;
      mem_lo_d    = mem_lo;
      hilo_d      = hilo_o;
      cnt_d       = cnt_o;
`ifdef EX_MEM_LS_EN
      mem_aluop_d    = mem_aluop;
      mem_mem_addr_d = mem_mem_addr;
      mem_reg2_d     = mem_reg2;
`endif
      unique case (act)
         ActClear, ActBubble: begin
            mem_wd_d    = '0;
            mem_wreg_d  = 1'b0;
            mem_wdata_d = '0;
            mem_whilo_d = 1'b0;
            mem_hi_d    = '0;
            mem_lo_d    = '0;
`ifdef EX_MEM_LS_EN
            mem_aluop_d    = 8'h00;
            mem_mem_addr_d = '0;
            mem_reg2_d     = '0;
`endif
            // A bubble keeps the multi-cycle scratch alive for EX; a clear restarts it.
            if (act == ActBubble) begin
               hilo_d = hilo_i;
               cnt_d  = cnt_i;
            end else begin
               hilo_d = '0;
               cnt_d  = '0;
            end
         end
         ActAdvance: begin
            mem_wd_d    = ex_wd;
            mem_wreg_d  = ex_wreg;
            mem_wdata_d = ex_wdata;
            mem_whilo_d = ex_whilo;
            mem_hi_d    = ex_hi;
            mem_lo_d    = ex_lo;
            hilo_d      = '0;
            cnt_d       = '0;
`ifdef EX_MEM_LS_EN
            mem_aluop_d    = ex_aluop;
            mem_mem_addr_d = ex_mem_addr;
            mem_reg2_d     = ex_reg2;
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      mem_wd    <= mem_wd_d;
      mem_wreg  <= mem_wreg_d;
      mem_wdata <= mem_wdata_d;
      mem_whilo <= mem_whilo_d;
      mem_hi    <= mem_hi_d;
      mem_lo    <= mem_lo_d;
      hilo_o    <= hilo_d;
      cnt_o     <= cnt_d;
`ifdef EX_MEM_LS_EN
      mem_aluop    <= mem_aluop_d;
      mem_mem_addr <= mem_mem_addr_d;
      mem_reg2     <= mem_reg2_d;
`endif
   end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios plus randomized traffic against a model.
// Define EX_MEM_LS_EN to also exercise the load/store payload.
module tb_ex_mem_reg;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 2;
`ifdef EX_MEM_LS_EN
   localparam int PW = AW + 2 + 3*DW + 8 + 2*DW;
`else
   localparam int PW = AW + 2 + 3*DW;
`endif
   localparam int SW = 2*DW + CW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, flush;
   logic [5:0]    stall;
   logic [AW-1:0] ex_wd;
   logic          ex_wreg, ex_whilo;
   logic [DW-1:0] ex_wdata, ex_hi, ex_lo;
   logic [2*DW-1:0] hilo_i, hilo_o;
   logic [CW-1:0] cnt_i, cnt_o;
   logic [AW-1:0] mem_wd;
   logic          mem_wreg, mem_whilo;
   logic [DW-1:0] mem_wdata, mem_hi, mem_lo;
`ifdef EX_MEM_LS_EN
   logic [7:0]    ex_aluop, mem_aluop;
   logic [DW-1:0] ex_mem_addr, ex_reg2, mem_mem_addr, mem_reg2;
`endif

   ex_mem_reg #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .flush     (flush),
      .ex_wd     (ex_wd),
      .ex_wreg   (ex_wreg),
      .ex_wdata  (ex_wdata),
      .ex_whilo  (ex_whilo),
      .ex_hi     (ex_hi),
      .ex_lo     (ex_lo),
      .hilo_i    (hilo_i),
      .cnt_i     (cnt_i),
      .mem_wd    (mem_wd),
      .mem_wreg  (mem_wreg),
      .mem_wdata (mem_wdata),
      .mem_whilo (mem_whilo),
      .mem_hi    (mem_hi),
      .mem_lo    (mem_lo),
      .hilo_o    (hilo_o),
      .cnt_o     (cnt_o)
`ifdef EX_MEM_LS_EN
      ,
      .ex_aluop    (ex_aluop),
      .ex_mem_addr (ex_mem_addr),
      .ex_reg2     (ex_reg2),
      .mem_aluop   (mem_aluop),
      .mem_mem_addr(mem_mem_addr),
      .mem_reg2    (mem_reg2)
`endif
   );

   wire [PW-1:0] dut_pay = {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo
`ifdef EX_MEM_LS_EN
                            , mem_aluop, mem_mem_addr, mem_reg2
`endif
                           };
   wire [PW-1:0] ex_pay = {ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo
`ifdef EX_MEM_LS_EN
                           , ex_aluop, ex_mem_addr, ex_reg2
`endif
                          };
   wire [SW-1:0] dut_scr = {hilo_o, cnt_o};
   wire [SW-1:0] in_scr  = {hilo_i, cnt_i};

   // Reference model: what MEM should see and what EX should get back after each edge.
   logic [PW-1:0] m_pay;
   logic [SW-1:0] m_scr;
   always @(posedge clk) begin
      if (rst || flush) begin
         m_pay <= '0;
         m_scr <= '0;
      end else if (!stall[3]) begin
         m_pay <= ex_pay;
         m_scr <= '0;
      end else if (!stall[4]) begin
         m_pay <= '0;
         m_scr <= in_scr;
      end
   end

   always @(posedge clk) begin
      if (!rst) assert (!(stall[4] && !stall[3])) else $error("illegal stall vector %b", stall);
   end

   int n_total = 0;
   int n_pass  = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'hDEADBEEF;
      ex_whilo = 1'b1; ex_hi = 32'h11; ex_lo = 32'h22;
      hilo_i = 64'h1234; cnt_i = 2'd3;
      tick();
      tick();
      n_total++;
      if ({dut_pay, dut_scr} !== '0)
         $display("FAIL reset_clear: got pay=%h scr=%h want 0", dut_pay, dut_scr);
      else n_pass++;
      rst = 1'b0;
      tick();
      n_total++;
      if ({mem_wd, mem_wreg, mem_wdata} !== {5'd3, 1'b1, 32'hDEADBEEF})
         $display("FAIL reset_release: got wd=%0d wreg=%b wdata=%h want 3 1 deadbeef",
                  mem_wd, mem_wreg, mem_wdata);
      else n_pass++;
   endtask

   task automatic test_advance();
      stall = 6'b0; ex_whilo = 1'b1; ex_hi = 32'h1; ex_lo = 32'h2;
      tick();
      n_total++;
      if ({mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o} !== {1'b1, 32'h1, 32'h2, 64'h0, 2'd0})
         $display("FAIL advance: got whilo=%b hi=%h lo=%h hilo=%h cnt=%0d want 1 1 2 0 0",
                  mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o);
      else n_pass++;
   endtask

   task automatic test_bubble();
      stall = 6'b001111; hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
      tick();
      n_total++;
      if ({mem_wreg, mem_wd, hilo_o, cnt_o} !== {1'b0, 5'd0, 64'h0000_0001_0000_0002, 2'd1})
         $display("FAIL bubble: got wreg=%b wd=%0d hilo=%h cnt=%0d want 0 0 100000002 1",
                  mem_wreg, mem_wd, hilo_o, cnt_o);
      else n_pass++;
      n_total++;
      if (dut_pay !== '0) $display("FAIL bubble_payload: got %h want 0", dut_pay);
      else n_pass++;
      stall = 6'b0; ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678;
      tick();
      n_total++;
      if ({mem_wd, mem_wdata, hilo_o, cnt_o} !== {5'd7, 32'h1234_5678, 64'h0, 2'd0})
         $display("FAIL bubble_release: got wd=%0d wdata=%h hilo=%h cnt=%0d want 7 12345678 0 0",
                  mem_wd, mem_wdata, hilo_o, cnt_o);
      else n_pass++;
   endtask

   task automatic test_hold();
      logic [CW-1:0] cnt_before;
      stall = 6'b0; ex_wdata = 32'hA5A5A5A5;
      tick();
      cnt_before = cnt_o;
      stall = 6'b011111;
      for (int i = 0; i < 3; i++) begin
         ex_wdata = $urandom; cnt_i = CW'(i + 1); hilo_i = {$urandom, $urandom};
         tick();
         n_total++;
         if (mem_wdata !== 32'hA5A5A5A5 || cnt_o !== cnt_before)
            $display("FAIL hold cycle %0d: got wdata=%h cnt=%0d want a5a5a5a5 %0d",
                     i, mem_wdata, cnt_o, cnt_before);
         else n_pass++;
      end
   endtask

   task automatic test_flush();
      stall = 6'b0; ex_wd = 5'd9; ex_wreg = 1'b1;
      tick();
      n_total++;
      if (mem_wreg !== 1'b1) $display("FAIL flush_setup: got wreg=%b want 1", mem_wreg);
      else n_pass++;
      flush = 1'b1; stall = 6'b011111; cnt_i = 2'd2;
      tick();
      n_total++;
      if ({mem_wreg, mem_wd, cnt_o} !== {1'b0, 5'd0, 2'd0})
         $display("FAIL flush_priority: got wreg=%b wd=%0d cnt=%0d want 0 0 0",
                  mem_wreg, mem_wd, cnt_o);
      else n_pass++;
      flush = 1'b0; stall = 6'b0;
   endtask

`ifdef EX_MEM_LS_EN
   task automatic test_ls();
      stall = 6'b0; ex_aluop = 8'hE3; ex_mem_addr = 32'h100; ex_reg2 = 32'hCAFE;
      tick();
      n_total++;
      if ({mem_aluop, mem_mem_addr, mem_reg2} !== {8'hE3, 32'h100, 32'hCAFE})
         $display("FAIL ls_capture: got aluop=%h addr=%h reg2=%h want e3 100 cafe",
                  mem_aluop, mem_mem_addr, mem_reg2);
      else n_pass++;
      stall = 6'b001111;
      tick();
      n_total++;
      if ({mem_aluop, mem_mem_addr, mem_reg2} !== '0)
         $display("FAIL ls_bubble: got aluop=%h addr=%h reg2=%h want 0 0 0",
                  mem_aluop, mem_mem_addr, mem_reg2);
      else n_pass++;
      stall = 6'b0;
   endtask
`endif

   task automatic test_random();
      logic [2:0] low;
      for (int i = 0; i < 400; i++) begin
         rst   = ($urandom_range(0, 31) == 0);
         flush = ($urandom_range(0, 15) == 0);
         low   = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 2))
            0:       stall = {3'b000, low};
            1:       stall = {3'b001, low};
            default: stall = {3'b111, low};
         endcase
         ex_wd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         ex_wreg  = 1'($urandom);
         ex_wdata = $urandom;
         ex_whilo = 1'($urandom);
         ex_hi    = $urandom;
         ex_lo    = $urandom;
         hilo_i   = {$urandom, $urandom};
         cnt_i    = 2'($urandom);
`ifdef EX_MEM_LS_EN
         ex_aluop    = 8'($urandom);
         ex_mem_addr = $urandom;
         ex_reg2     = $urandom;
`endif
         tick();
         n_total++;
         if (dut_pay !== m_pay)
            $display("FAIL rand_payload cycle %0d: got %h want %h", i, dut_pay, m_pay);
         else n_pass++;
         n_total++;
         if (dut_scr !== m_scr)
            $display("FAIL rand_scratch cycle %0d: got %h want %h", i, dut_scr, m_scr);
         else n_pass++;
      end
      rst = 1'b0; flush = 1'b0; stall = 6'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; stall = 6'b0;
      ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_whilo = 1'b0; ex_hi = '0; ex_lo = '0;
      hilo_i = '0; cnt_i = '0;
`ifdef EX_MEM_LS_EN
      ex_aluop = '0; ex_mem_addr = '0; ex_reg2 = '0;
`endif
      test_reset();
      test_advance();
      test_bubble();
      test_hold();
      test_flush();
`ifdef EX_MEM_LS_EN
      test_ls();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
